uart_tx_arb: RTL and testbench

Round-robin arbiter sharing one UART transmitter (`uart_tx`) between `NUM_REQ` byte producers. It accepts one byte at a time from a requester through a valid/ready handshake and issues it to the transmitter as a single-cycle write strobe. It then tracks the transmitter's `idle` flag until the frame completes before granting again. It sits between the peripheral bus/DMA-side producers and the `uart_tx` instance in the peripheral subsystem.

---
 rtl/uart_tx_arb.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx between NUM_REQ byte producers.
// A byte is accepted through a valid/ready handshake and issued as a
// one-cycle write strobe. No new grant is made until the frame completes.
// Optional feature: define UART_TX_ARB_PRIO_EN to give requester 0 fixed
// absolute priority. The remaining requesters then share round-robin.
//
// state      | meaning
// IDLE       | waiting for enable, idle transmitter and a pending request
// ISSUE      | write strobe to uart_tx, start-timeout counter cleared
// WAIT_START | waiting for tx_idle_i to fall (bounded by START_TIMEOUT)
// WAIT_DONE  | frame in flight, waiting for tx_idle_i to return
module uart_tx_arb #(
  parameter int  NUM_REQ       = 4,
  parameter int  START_TIMEOUT = 16,
  localparam int IdW           = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 arb_enable_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_enable_o,
  output logic                 tx_wr_o,
  output logic [7:0]           tx_wr_data_o,
  input  logic                 tx_idle_i,
  output logic                 busy_o,
  output logic [IdW-1:0]       grant_id_o,
  output logic                 err_timeout_o
);

`ifdef UART_TX_ARB_PRIO_EN
  localparam bit PrioEn = 1'b1;
`else
  localparam bit PrioEn = 1'b0;
`endif

  localparam logic [IdW-1:0] PtrRst  = IdW'(NUM_REQ - 1);
  localparam logic [7:0]     CntLast = 8'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] grant_id_q, grant_id_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           win_found;
  logic [IdW-1:0] win_idx;
  logic [IdW-1:0] cand_idx;
  int             cand;

  // Winner search: first valid requester above ptr, wrapping; requester 0
  // is pulled out of the rotation when it has fixed priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (PrioEn && req_valid_i[0]) begin
      win_found = 1'b1;
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % NUM_REQ;
      cand_idx = IdW'(cand);
      if (!win_found && req_valid_i[cand_idx] && !(PrioEn && cand_idx == '0)) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and strobe outputs.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    req_ready_o   = '0;
    tx_wr_o       = 1'b0;
    err_timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst_i && arb_enable_i && tx_idle_i && win_found) begin
          req_ready_o = NUM_REQ'(1) << win_idx;
          data_d      = req_data_i[8*win_idx +: 8];
          grant_id_d  = win_idx;
          if (!(PrioEn && win_idx == '0)) begin
            ptr_d = win_idx;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tx_wr_o = !rst_i;
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!tx_idle_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CntLast) begin
          // Transmitter never started: drop the byte, no retry.
          err_timeout_o = !rst_i;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (tx_idle_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= PtrRst;
      grant_id_q <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  // A frame in flight keeps the transmitter enabled even if arbitration stops.
  assign tx_enable_o  = !rst_i && (arb_enable_i || busy_o);
  assign grant_id_o   = grant_id_q;
  assign tx_wr_data_o = data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb (NUM_REQ=4, START_TIMEOUT=16) with a behavioural uart_tx.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst_i;
  logic        arb_enable_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        tx_enable_o;
  logic        tx_wr_o;
  logic [7:0]  tx_wr_data_o;
  logic        tx_idle_i;
  logic        busy_o;
  logic [1:0]  grant_id_o;
  logic        err_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural transmitter: idle drops the cycle after the write strobe and
  // stays low for frame_len cycles. With model_en low, idle is force_idle.
  logic model_en;
  logic force_idle;
  int   frame_len;
  int   rem;

  uart_tx_arb #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .arb_enable_i (arb_enable_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .tx_enable_o  (tx_enable_o),
    .tx_wr_o      (tx_wr_o),
    .tx_wr_data_o (tx_wr_data_o),
    .tx_idle_i    (tx_idle_i),
    .busy_o       (busy_o),
    .grant_id_o   (grant_id_o),
    .err_timeout_o(err_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_i) rem <= 0;
    else if (model_en && tx_wr_o) rem <= frame_len;
    else if (rem > 0) rem <= rem - 1;
  end
  assign tx_idle_i = model_en ? (rem == 0) : force_idle;

  // Reference arbitration rule on a valid mask and last rotation pointer.
  function automatic int pick(input logic [3:0] v, input int p);
`ifdef UART_TX_ARB_PRIO_EN
    if (v[0]) return 0;
    for (int k = 1; k <= 4; k++) begin
      if (((p + k) % 4) != 0 && v[(p + k) % 4]) return (p + k) % 4;
    end
`else
    for (int k = 1; k <= 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
`endif
    return -1;
  endfunction

  function automatic int next_ptr(input int p, input int w);
`ifdef UART_TX_ARB_PRIO_EN
    return (w == 0) ? p : w;
`else
    return w;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; arb_enable_i = 1'b1;
    model_en = 1'b1; force_idle = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; arb_enable_i = 1'b1; req_valid_i = 4'hF; req_data_i = 32'hD4C3B2A1;
    model_en = 1'b1; force_idle = 1'b1; frame_len = 4;
    repeat (3) begin
      @(negedge clk); #1;
      n_tests++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
      n_tests++; if (tx_wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b exp=0", tx_wr_o); end
      n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      n_tests++; if (err_timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_timeout_o); end
      n_tests++; if (tx_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_txen got=%b exp=0", tx_enable_o); end
      n_tests++; if (tx_wr_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", tx_wr_data_o); end
      n_tests++; if (grant_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_gid got=%0d exp=0", grant_id_o); end
    end
    rst_i = 1'b0; #1;
    n_tests++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready_o); end
    @(negedge clk); req_valid_i = '0; #1;
    n_tests++; if (tx_wr_o !== 1'b1 || tx_wr_data_o !== 8'hA1) begin n_fail++; $display("FAIL reset_first_wr got=%b/%h exp=1/a1", tx_wr_o, tx_wr_data_o); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int d;
    do_reset();
    frame_len = 10;
    req_valid_i = 4'b0100; req_data_i = 32'h00A50000; #1;
    n_tests++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready_o); end
    @(negedge clk);
    req_valid_i = 4'b0010; req_data_i = 32'h00001100; #1;
    n_tests++; if (tx_wr_o !== 1'b1 || tx_wr_data_o !== 8'hA5) begin n_fail++; $display("FAIL single_wr got=%b/%h exp=1/a5", tx_wr_o, tx_wr_data_o); end
    n_tests++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL single_ready_busy got=%b exp=0000", req_ready_o); end
    d = 1;
    while (req_ready_o === 4'b0 && d < 50) begin @(negedge clk); #1; d++; end
    n_tests++; if (d !== 13) begin n_fail++; $display("FAIL single_spacing got=%0d exp=13", d); end
    n_tests++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL single_next got=%b exp=0010", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_fairness();
    int mptr, w, t_now, t_prev, waited;
    logic [3:0] exp_rdy;
    do_reset();
    frame_len = 2; mptr = 3; t_now = 0; t_prev = 0;
    req_valid_i = 4'hF; req_data_i = 32'h13121110;
    #1;
    for (int g = 0; g < 6; g++) begin
      waited = 0;
      while (req_ready_o === 4'b0 && waited < 20) begin @(negedge clk); #1; waited++; t_now++; end
      n_tests++; if (waited >= 20) begin n_fail++; $display("FAIL fair_wait got=no_grant exp=grant g=%0d", g); end
      w = pick(4'hF, mptr);
      exp_rdy = 4'b0001 << w;
      n_tests++; if (req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL fair_order g=%0d got=%b exp=%b", g, req_ready_o, exp_rdy); end
      if (g > 0) begin
        n_tests++; if (t_now - t_prev !== 5) begin n_fail++; $display("FAIL fair_spacing g=%0d got=%0d exp=5", g, t_now - t_prev); end
      end
      t_prev = t_now;
      mptr = next_ptr(mptr, w);
      @(negedge clk); #1; t_now++;
      n_tests++; if (grant_id_o !== 2'(w)) begin n_fail++; $display("FAIL fair_gid g=%0d got=%0d exp=%0d", g, grant_id_o, w); end
      n_tests++; if (tx_wr_o !== 1'b1 || tx_wr_data_o !== 8'(8'h10 + w)) begin n_fail++; $display("FAIL fair_wr g=%0d got=%b/%h exp=1/%h", g, tx_wr_o, tx_wr_data_o, 8'(8'h10 + w)); end
    end
    req_valid_i = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    model_en = 1'b0; force_idle = 1'b1;
    req_valid_i = 4'b0110; req_data_i = 32'h005A3C00; #1;
    n_tests++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL to_grant got=%b exp=0010", req_ready_o); end
    @(negedge clk); req_valid_i = 4'b0100; #1;
    n_tests++; if (tx_wr_o !== 1'b1 || tx_wr_data_o !== 8'h3C) begin n_fail++; $display("FAIL to_wr got=%b/%h exp=1/3c", tx_wr_o, tx_wr_data_o); end
    for (int c = 2; c <= 17; c++) begin
      @(negedge clk); #1;
      n_tests++; if (err_timeout_o !== (c == 17)) begin n_fail++; $display("FAIL to_err c=%0d got=%b exp=%b", c, err_timeout_o, (c == 17)); end
      n_tests++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL to_ready_busy c=%0d got=%b exp=0000", c, req_ready_o); end
    end
    @(negedge clk); #1;
    n_tests++; if (err_timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got=%b exp=0", err_timeout_o); end
    n_tests++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL to_next_grant got=%b exp=0100", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    repeat (20) @(negedge clk);
    model_en = 1'b1;
  endtask

  task automatic test_enable_drop();
    do_reset();
    frame_len = 6;
    req_valid_i = 4'b1000; req_data_i = 32'h77000000; #1;
    n_tests++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL en_grant got=%b exp=1000", req_ready_o); end
    @(negedge clk); req_valid_i = 4'b0001; req_data_i = 32'h00000001;
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      if (c == 4) arb_enable_i = 1'b0;
      #1;
      n_tests++; if (tx_enable_o !== (c <= 8)) begin n_fail++; $display("FAIL en_txen c=%0d got=%b exp=%b", c, tx_enable_o, (c <= 8)); end
      n_tests++; if (req_ready_o !== 4'b0) begin n_fail++; $display("FAIL en_ready c=%0d got=%b exp=0000", c, req_ready_o); end
    end
    @(negedge clk); arb_enable_i = 1'b1; #1;
    n_tests++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL en_resume got=%b exp=0001", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_midframe_reset();
    do_reset();
    frame_len = 4;
    req_valid_i = 4'b0001; req_data_i = 32'h000000C7; #1;
    n_tests++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL mrst_grant got=%b exp=0001", req_ready_o); end
    @(negedge clk); req_valid_i = '0; #1;
    n_tests++; if (tx_wr_o !== 1'b1) begin n_fail++; $display("FAIL mrst_wr got=%b exp=1", tx_wr_o); end
    rst_i = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (tx_wr_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mrst_state got=wr%b/busy%b exp=0/0", tx_wr_o, busy_o); end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef UART_TX_ARB_PRIO_EN
  task automatic test_prio();
    int waited;
    do_reset();
    frame_len = 2;
    req_valid_i = 4'b0011; req_data_i = 32'h0000B1B0; #1;
    for (int g = 0; g < 5; g++) begin
      if (g == 4) begin @(negedge clk); req_valid_i = 4'b0010; #1; end
      waited = 0;
      while (req_ready_o === 4'b0 && waited < 20) begin @(negedge clk); #1; waited++; end
      n_tests++; if (req_ready_o !== ((g == 4) ? 4'b0010 : 4'b0001)) begin n_fail++; $display("FAIL prio g=%0d got=%b exp=%b", g, req_ready_o, (g == 4) ? 4'b0010 : 4'b0001); end
      @(negedge clk); #1;
    end
    req_valid_i = '0;
    repeat (10) @(negedge clk);
  endtask
`endif

  task automatic test_random();
    logic [7:0] fifo [4][8];
    int hd[4], n[4];
    int allowed, last_t, mptr, exp_gid, w, r, flen;
    logic [7:0] exp_data;
    logic [3:0] exp_rdy;
    logic exp_busy, exp_wr;
    for (int i = 0; i < 4; i++) begin hd[i] = 0; n[i] = 0; end
    do_reset();
    allowed = 0; last_t = -10; mptr = 3; exp_gid = 0; exp_data = 8'h00;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (cyc < 700 && $urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 3);
        if (n[r] < 8) begin fifo[r][(hd[r] + n[r]) % 8] = 8'($urandom); n[r]++; end
      end
      arb_enable_i = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 4; i++) begin
        req_valid_i[i] = (n[i] > 0);
        req_data_i[8*i +: 8] = (n[i] > 0) ? fifo[i][hd[i]] : 8'h00;
      end
      #1;
      exp_rdy = '0; w = -1;
      if (arb_enable_i && cyc >= allowed && req_valid_i != 4'b0) begin
        w = pick(req_valid_i, mptr);
        exp_rdy = 4'b0001 << w;
      end
      exp_busy = (cyc > last_t) && (cyc < allowed);
      exp_wr   = (cyc == last_t + 1);
      n_tests++; if (req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_rdy); end
      n_tests++; if (tx_wr_o !== exp_wr) begin n_fail++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", cyc, tx_wr_o, exp_wr); end
      n_tests++; if (busy_o !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy_o, exp_busy); end
      n_tests++; if (tx_enable_o !== (arb_enable_i | exp_busy)) begin n_fail++; $display("FAIL rnd_txen cyc=%0d got=%b exp=%b", cyc, tx_enable_o, arb_enable_i | exp_busy); end
      n_tests++; if (grant_id_o !== 2'(exp_gid)) begin n_fail++; $display("FAIL rnd_gid cyc=%0d got=%0d exp=%0d", cyc, grant_id_o, exp_gid); end
      n_tests++; if (tx_wr_data_o !== exp_data) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, tx_wr_data_o, exp_data); end
      n_tests++; if (err_timeout_o !== 1'b0) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=0", cyc, err_timeout_o); end
      if (w >= 0) begin
        flen      = $urandom_range(1, 6);
        frame_len = flen;
        last_t    = cyc;
        allowed   = cyc + 3 + flen;
        exp_gid   = w;
        exp_data  = fifo[w][hd[w]];
        mptr      = next_ptr(mptr, w);
        hd[w]     = (hd[w] + 1) % 8;
        n[w]--;
      end
    end
    req_valid_i = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_fairness();
    test_timeout();
    test_enable_drop();
    test_midframe_reset();
`ifdef UART_TX_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
